// File: rtl/cnt8_core_if.sv
// rtl/cnt8_core_if.sv - tick, control and count bundle for cnt8_core
interface cnt8_core_if;
   logic       tick_in;
   logic       en;
   logic       dir;
   logic       mode;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] count;
   logic       tc;
   logic       dir_out;

   modport master (
      output tick_in, en, dir, mode, load, load_val,
      input  count, tc, dir_out
   );

   modport slave (
      input  tick_in, en, dir, mode, load, load_val,
      output count, tc, dir_out
   );
endinterface

// File: rtl/cnt8_core.sv
// rtl/cnt8_core.sv - 8-bit up/down wrap/bounce counter stepped by a synchronised divider tick; CNT8_BCD_EN selects packed-BCD counting
module cnt8_core #(
   parameter logic [7:0] MIN_VAL = 8'h00,
`ifdef CNT8_BCD_EN
   parameter logic [7:0] MAX_VAL = 8'h99,
`else
   parameter logic [7:0] MAX_VAL = 8'hFF,
`endif
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic        clk50m,
   input logic        rst_n,
   cnt8_core_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

   // Limits as signed ints so range checks stay ordinary compares at any limit value
   localparam int MIN_I = int'(MIN_VAL);
   localparam int MAX_I = int'(MAX_VAL);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   step;

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic       tc_q, tc_d;
   logic       dir_out_q, dir_out_d;

   logic [7:0] inc_v, dec_v;
   logic       at_max, at_min, inc_hits_max, dec_hits_min;

   function automatic logic [7:0] inc8(input logic [7:0] v);
`ifdef CNT8_BCD_EN
      if (v[3:0] >= 4'd9)
         return {(v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
`else
      return v + 8'd1;
`endif
   endfunction

   function automatic logic [7:0] dec8(input logic [7:0] v);
`ifdef CNT8_BCD_EN
      if (v[3:0] == 4'd0)
         return {(v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
`else
      return v - 8'd1;
`endif
   endfunction

   // Loaded values are forced into [MIN_VAL, MAX_VAL]; a malformed BCD code saturates high first
   function automatic logic [7:0] clamp_load(input logic [7:0] v);
      logic [7:0] c;
      c = v;
`ifdef CNT8_BCD_EN
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9)
         c = 8'h99;
`endif
      if (int'(c) < MIN_I)
         c = MIN_VAL;
      else if (int'(c) > MAX_I)
         c = MAX_VAL;
      return c;
   endfunction

   // Synchroniser chain plus history flop for the rising-edge detector
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.tick_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign step = sync_q[SYNC_STAGES-1] & ~hist_q;

   assign inc_v        = inc8(count_q);
   assign dec_v        = dec8(count_q);
   assign at_max       = int'(count_q) >= MAX_I;
   assign at_min       = int'(count_q) <= MIN_I;
   assign inc_hits_max = int'(inc_v) == MAX_I;
   assign dec_hits_min = int'(dec_v) == MIN_I;

   // Next state, next count and terminal-count pulse; load outranks any step
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      tc_d      = 1'b0;
      dir_out_d = dir_out_q;

      if (bus.load) begin
         count_d = clamp_load(bus.load_val);
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.en)
                  state_d = bus.dir ? S_UP : S_DOWN;
            end
            default: begin
               if (!bus.en) begin
                  state_d = S_IDLE;
               end else if (step) begin
                  if (!bus.mode) begin
                     // Wrap: dir is re-sampled on every step and applies to that step
                     state_d = bus.dir ? S_UP : S_DOWN;
                     if (bus.dir) begin
                        if (at_max) begin
                           count_d = MIN_VAL;
                           tc_d    = 1'b1;
                        end else begin
                           count_d = inc_v;
                        end
                     end else begin
                        if (at_min) begin
                           count_d = MAX_VAL;
                           tc_d    = 1'b1;
                        end else begin
                           count_d = dec_v;
                        end
                     end
                  end else if (state_q == S_UP) begin
                     // Bounce: a count already parked on the limit (after a load) just turns round
                     if (at_max) begin
                        count_d = dec_v;
                        state_d = S_DOWN;
                     end else begin
                        count_d = inc_v;
                        if (inc_hits_max) begin
                           state_d = S_DOWN;
                           tc_d    = 1'b1;
                        end
                     end
                  end else begin
                     if (at_min) begin
                        count_d = inc_v;
                        state_d = S_UP;
                     end else begin
                        count_d = dec_v;
                        if (dec_hits_min) begin
                           state_d = S_UP;
                           tc_d    = 1'b1;
                        end
                     end
                  end
               end
            end
         endcase
      end

      case (state_d)
         S_UP:    dir_out_d = 1'b1;
         S_DOWN:  dir_out_d = 1'b0;
         default: dir_out_d = dir_out_q;
      endcase
   end

   // State, count and registered outputs
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         count_q   <= MIN_VAL;
         tc_q      <= 1'b0;
         dir_out_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         tc_q      <= tc_d;
         dir_out_q <= dir_out_d;
      end
   end

   assign bus.count   = count_q;
   assign bus.tc      = tc_q;
   assign bus.dir_out = dir_out_q;

endmodule

// File: tb/tb_cnt8_core.sv
// tb/tb_cnt8_core.sv - directed and randomized checks of cnt8_core against a behavioural model
module tb_cnt8_core;

   localparam int SYNC = 2;
`ifdef CNT8_BCD_EN
   localparam logic [7:0] MAX0 = 8'h99;
`else
   localparam logic [7:0] MAX0 = 8'hFF;
`endif

   logic       clk50m = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       en = 1'b0;
   logic       dir = 1'b0;
   logic       mode = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on = 1'b0;
   int lat, tcs0, tcs1;

   cnt8_core_if if0 ();
   cnt8_core_if if1 ();

   assign if0.tick_in  = tick;
   assign if0.en       = en;
   assign if0.dir      = dir;
   assign if0.mode     = mode;
   assign if0.load     = load;
   assign if0.load_val = load_val;
   assign if1.tick_in  = tick;
   assign if1.en       = en;
   assign if1.dir      = dir;
   assign if1.mode     = mode;
   assign if1.load     = load;
   assign if1.load_val = load_val;

   cnt8_core #(.MIN_VAL(8'h00), .MAX_VAL(MAX0), .SYNC_STAGES(SYNC)) dut0 (
      .clk50m (clk50m),
      .rst_n  (rst_n),
      .bus    (if0)
   );

   cnt8_core #(.MIN_VAL(8'h03), .MAX_VAL(8'h06), .SYNC_STAGES(SYNC)) dut1 (
      .clk50m (clk50m),
      .rst_n  (rst_n),
      .bus    (if1)
   );

   always #10 clk50m = ~clk50m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model works on plain decimal numbers; conversion to/from the count code only at the edges
   typedef struct packed {
      int c;
      bit up;
      bit run;
      bit tc;
   } ms_t;

   ms_t m0, m1;
   bit  sq[$];

   function automatic int to_num(input logic [7:0] v);
`ifdef CNT8_BCD_EN
      return int'(v[7:4]) * 10 + int'(v[3:0]);
`else
      return int'(v);
`endif
   endfunction

   function automatic logic [7:0] to_code(input int n);
`ifdef CNT8_BCD_EN
      return {4'(n / 10), 4'(n % 10)};
`else
      return 8'(n);
`endif
   endfunction

   function automatic ms_t m_reset(input int lo);
      ms_t r;
      r.c = lo; r.up = 1'b1; r.run = 1'b0; r.tc = 1'b0;
      return r;
   endfunction

   function automatic ms_t m_next(input ms_t s, input bit st, input int lo, input int hi);
      ms_t r;
      int  n;
      r = s;
      r.tc = 1'b0;
      if (load) begin
`ifdef CNT8_BCD_EN
         if (load_val[7:4] > 4'd9 || load_val[3:0] > 4'd9) n = 99;
         else n = to_num(load_val);
`else
         n = int'(load_val);
`endif
         r.c = (n < lo) ? lo : ((n > hi) ? hi : n);
      end else if (!s.run) begin
         if (en) begin
            r.run = 1'b1;
            r.up  = dir;
         end
      end else if (!en) begin
         r.run = 1'b0;
      end else if (st) begin
         if (!mode) begin
            r.up = dir;
            if (dir) begin
               if (s.c == hi) begin r.c = lo; r.tc = 1'b1; end
               else r.c = s.c + 1;
            end else begin
               if (s.c == lo) begin r.c = hi; r.tc = 1'b1; end
               else r.c = s.c - 1;
            end
         end else if (s.up) begin
            if (s.c == hi) begin r.up = 1'b0; r.c = s.c - 1; end
            else begin
               r.c = s.c + 1;
               if (r.c == hi) begin r.up = 1'b0; r.tc = 1'b1; end
            end
         end else begin
            if (s.c == lo) begin r.up = 1'b1; r.c = s.c + 1; end
            else begin
               r.c = s.c - 1;
               if (r.c == lo) begin r.up = 1'b1; r.tc = 1'b1; end
            end
         end
      end
      return r;
   endfunction

   // A tick_in rise sampled at edge k acts on the count at edge k+SYNC
   always @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         m0 = m_reset(0);
         m1 = m_reset(3);
         sq.delete();
         for (int i = 0; i < SYNC + 2; i++) sq.push_back(1'b0);
      end else begin
         bit st;
         sq.push_back(tick);
         void'(sq.pop_front());
         st = sq[1] & ~sq[0];
         m0 = m_next(m0, st, 0, to_num(MAX0));
         m1 = m_next(m1, st, 3, 6);
      end
   end

   always @(negedge clk50m) begin
      if (chk_on) begin
         check("count0", {24'd0, if0.count}, {24'd0, to_code(m0.c)});
         check("tc0", {31'd0, if0.tc}, {31'd0, m0.tc});
         check("dir0", {31'd0, if0.dir_out}, {31'd0, m0.up});
         check("count1", {24'd0, if1.count}, {24'd0, to_code(m1.c)});
         check("tc1", {31'd0, if1.tc}, {31'd0, m1.tc});
         check("dir1", {31'd0, if1.dir_out}, {31'd0, m1.up});
      end
   end

   // One tick_in period starting at posedge+1; records dut0 latency and tc pulses seen
   task automatic do_tick(input int hc, input int lc, input int ld_at, input int en_at);
      logic [7:0] c0;
      c0   = if0.count;
      lat  = -1;
      tcs0 = 0;
      tcs1 = 0;
      tick = 1'b1;
      for (int i = 1; i <= hc + lc; i++) begin
         @(posedge clk50m); #1;
         if (lat < 0 && if0.count !== c0) lat = i;
         tcs0 += int'(if0.tc);
         tcs1 += int'(if1.tc);
         if (i == hc) tick = 1'b0;
         if (ld_at >= 0) load = (i == ld_at);
         if (i == en_at) en = 1'b1;
      end
      if (ld_at >= 0) load = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] v);
      load_val = v;
      load     = 1'b1;
      @(posedge clk50m); #1;
      load     = 1'b0;
   endtask

   int bexp [7] = '{4, 5, 6, 5, 4, 3, 4};
   int btc  [7] = '{0, 0, 1, 0, 0, 1, 0};
   int bdir [7] = '{1, 1, 0, 0, 0, 1, 1};

   initial begin
      repeat (3) @(posedge clk50m);
      #1 chk_on = 1'b1;
      check("rst_count0", {24'd0, if0.count}, 32'h00);
      check("rst_tc0", {31'd0, if0.tc}, 32'd0);
      check("rst_dir0", {31'd0, if0.dir_out}, 32'd1);
      check("rst_count1", {24'd0, if1.count}, 32'h03);
      rst_n = 1'b1;
      en    = 1'b1;
      dir   = 1'b1;
      mode  = 1'b0;
      repeat (2) begin @(posedge clk50m); #1; end

`ifndef CNT8_BCD_EN
      do_tick(5, 5, -1, -1);
      check("lat1", lat, 3);
      check("seq1", {24'd0, if0.count}, 32'h01);
      do_tick(5, 5, -1, -1);
      check("lat2", lat, 3);
      check("seq2", {24'd0, if0.count}, 32'h02);

      do_load(8'hFE);
      do_tick(5, 5, -1, -1);
      check("wrapFF", {24'd0, if0.count}, 32'hFF);
      check("tcFF", tcs0, 0);
      do_tick(5, 5, -1, -1);
      check("wrap00", {24'd0, if0.count}, 32'h00);
      check("tc00", tcs0, 1);

      load_val = 8'h0A;
      do_tick(5, 5, 2, -1);
      check("ldstep", {24'd0, if0.count}, 32'h0A);
      do_tick(5, 5, -1, -1);
      check("ldnext", {24'd0, if0.count}, 32'h0B);

      mode = 1'b1;
      do_load(8'h00);
      check("bload", {24'd0, if1.count}, 32'h03);
      for (int i = 0; i < 7; i++) begin
         do_tick(5, 5, -1, -1);
         check("bcnt", {24'd0, if1.count}, bexp[i]);
         check("btc", tcs1, btc[i]);
         check("bdir", {31'd0, if1.dir_out}, bdir[i]);
      end

      mode = 1'b0;
      dir  = 1'b1;
      do_load(8'h40);
      check("pre_rst", {24'd0, if0.count}, 32'h40);
      tick = 1'b1;
      @(posedge clk50m);
      #5 rst_n = 1'b0;
      #1;
      check("arst_cnt", {24'd0, if0.count}, 32'h00);
      check("arst_tc", {31'd0, if0.tc}, 32'd0);
      tick = 1'b0;
      en   = 1'b0;
      @(posedge clk50m); #1 rst_n = 1'b1;
      do_tick(5, 5, -1, -1);
      check("idle_hold", {24'd0, if0.count}, 32'h00);
      do_tick(5, 5, -1, 2);
      check("idle_drop", {24'd0, if0.count}, 32'h00);
      do_tick(5, 5, -1, -1);
      check("idle_first", {24'd0, if0.count}, 32'h01);
`else
      do_load(8'h98);
      do_tick(5, 5, -1, -1);
      check("bcd99", {24'd0, if0.count}, 32'h99);
      do_tick(5, 5, -1, -1);
      check("bcd00", {24'd0, if0.count}, 32'h00);
      check("bcdtc", tcs0, 1);
      do_load(8'h10);
      dir = 1'b0;
      do_tick(5, 5, -1, -1);
      check("bcd09", {24'd0, if0.count}, 32'h09);
`endif

      for (int it = 0; it < 300; it++) begin
         en  = ($urandom_range(0, 7) != 0);
         dir = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) mode = ~mode;
         load_val = 8'($urandom_range(0, 255));
         do_tick(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : -1, -1);
         if ($urandom_range(0, 39) == 0) begin
            @(posedge clk50m);
            #4 rst_n = 1'b0;
            #2;
            check("rnd_arst", {24'd0, if0.count}, 32'h00);
            @(posedge clk50m); #1 rst_n = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
